// File: rtl/hc165_reader.sv
// hc165_reader: periodic snapshot reader for a chain of 74HC165 shift registers.
// Produces registered SH/LD# and CLK strobes and reports each completed scan.
module hc165_reader #(
   parameter int CLK_DIV  = 25,
   parameter int WIDTH    = 32,
   parameter int SCAN_GAP = 1000
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   output logic             sh_ld_n,
   output logic             sh_clk,
   input  logic             sh_dat,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             changed,
   output logic             busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(SCAN_GAP + 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(SCAN_GAP);
   localparam logic [GW-1:0] GAP_LAST = GW'(SCAN_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [DW-1:0]    r_div;
   logic [BW-1:0]    r_bit;
   logic [GW-1:0]    r_gap;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_data;
   logic             r_first;
   logic             r_ld_n;
   logic             r_clk;
   logic             r_valid;
   logic             r_changed;
   logic             r_busy;

   logic             w_div_last;
   logic             w_gap_done;
   logic             w_phase;
   logic             w_sample;
   logic             w_enter_done;
   logic             w_diff;
   logic             w_ld_n_nxt;
   logic             w_clk_nxt;
   logic             w_valid_nxt;
   logic             w_busy_nxt;

   assign w_div_last   = (r_div == DIV_LAST);
   // The cycle holding GAP_LAST is the last idle cycle, so the
   // steady-state idle stretch is exactly SCAN_GAP cycles long.
   assign w_gap_done   = (r_gap >= GAP_LAST);
   assign w_phase      = (r_state == S_LOAD)     ||
                         (r_state == S_SETTLE)   ||
                         (r_state == S_SHIFT_LO) ||
                         (r_state == S_SHIFT_HI);
   assign w_sample     = (r_state == S_SHIFT_LO) && w_div_last;
   assign w_enter_done = (w_state_nxt == S_DONE);
   assign w_diff       = (r_shift != r_data) || r_first;

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: each timed phase ends on its last divider cycle
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (en && w_gap_done) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_div_last) begin
               w_state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (w_div_last) begin
               w_state_nxt = S_SHIFT_LO;
            end
         end
         S_SHIFT_LO: begin
            if (w_div_last) begin
               w_state_nxt = S_SHIFT_HI;
            end
         end
         S_SHIFT_HI: begin
            if (w_div_last) begin
               if (r_bit == BIT_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_SHIFT_LO;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the pins are registered
   // yet line up exactly with the state they belong to
   always_comb begin
      w_ld_n_nxt  = 1'b1;
      w_clk_nxt   = 1'b0;
      w_valid_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
      unique case (w_state_nxt)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
         end
         S_LOAD: begin
            w_ld_n_nxt = 1'b0;
         end
         S_SETTLE: begin
            w_ld_n_nxt = 1'b1;
         end
         S_SHIFT_LO: begin
            w_clk_nxt = 1'b0;
         end
         S_SHIFT_HI: begin
            w_clk_nxt = 1'b1;
         end
         S_DONE: begin
            w_valid_nxt = 1'b1;
         end
         default: begin
            w_busy_nxt = 1'b0;
         end
      endcase
   end

   // Registered pin and status outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_ld_n  <= 1'b1;
         r_clk   <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ld_n  <= w_ld_n_nxt;
         r_clk   <= w_clk_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Phase divider: counts cycles within LOAD, SETTLE and both shift halves
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_div <= '0;
      end else if (w_phase && !w_div_last) begin
         r_div <= r_div + 1'b1;
      end else begin
         r_div <= '0;
      end
   end

   // Bit counter: cleared in SETTLE, advanced at the end of each high half
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_bit <= '0;
      end else if (r_state == S_SETTLE) begin
         r_bit <= '0;
      end else if ((r_state == S_SHIFT_HI) && w_div_last) begin
         r_bit <= r_bit + 1'b1;
      end
   end

   // Gap counter: saturating idle timer, restarted by each completed scan
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_gap <= '0;
      end else if (r_state == S_DONE) begin
         r_gap <= '0;
      end else if ((r_state == S_IDLE) && (r_gap != GAP_MAX)) begin
         r_gap <= r_gap + 1'b1;
      end
   end

   // Serial capture: QH has been stable for a whole low half when sampled,
   // so no synchronizer is needed; first bit ends up in the MSB
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_shift <= '0;
      end else if (w_sample) begin
         r_shift <= {r_shift[WIDTH-2:0], sh_dat};
      end
   end

   // Snapshot publish: data, change flag and first-scan tracking
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_data    <= '0;
         r_changed <= 1'b0;
         r_first   <= 1'b1;
      end else if (w_enter_done) begin
         r_data    <= r_shift;
         r_changed <= w_diff;
         r_first   <= 1'b0;
      end else begin
         r_changed <= 1'b0;
      end
   end

   assign sh_ld_n = r_ld_n;
   assign sh_clk  = r_clk;
   assign data    = r_data;
   assign valid   = r_valid;
   assign changed = r_changed;
   assign busy    = r_busy;

endmodule

// File: tb/tb_hc165_reader.sv
// tb_hc165_reader: drives hc165_reader against a behavioural 74HC165 chain
// and compares each snapshot with a scan-level reference model.
module tb_hc165_reader;

   localparam int CD  = 2;
   localparam int W   = 8;
   localparam int GAP = 4;
   localparam int PER = GAP + CD * (2 + 2 * W) + 1;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic         sh_ld_n;
   logic         sh_clk;
   logic         sh_dat;
   logic [W-1:0] data;
   logic         valid;
   logic         changed;
   logic         busy;

   logic [W-1:0] preset;
   logic [W-1:0] chain;
   logic [W-1:0] ref_last;
   logic [W-1:0] v;
   bit           ref_first;
   bit           p_clk;
   int           n_chk;
   int           n_err;
   int           n_cyc;
   int           n_rise;
   int           n_ld;
   int           c;
   bit           hit;

   hc165_reader #(
      .CLK_DIV (CD),
      .WIDTH   (W),
      .SCAN_GAP(GAP)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .en       (en),
      .sh_ld_n  (sh_ld_n),
      .sh_clk   (sh_clk),
      .sh_dat   (sh_dat),
      .data     (data),
      .valid    (valid),
      .changed  (changed),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 74HC165 chain: parallel load while SH/LD# low, shift toward QH on CLK rise
   always @(posedge sh_clk or negedge sh_ld_n) begin
      if (!sh_ld_n) begin
         chain <= preset;
      end else begin
         chain <= {chain[W-2:0], 1'b0};
      end
   end
   assign sh_dat = chain[W-1];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      n_cyc++;
      if (sh_clk && !p_clk) n_rise++;
      p_clk = sh_clk;
      if (!sh_ld_n) n_ld++;
   endtask

   task automatic clr();
      n_cyc  = 0;
      n_rise = 0;
      n_ld   = 0;
   endtask

   task automatic scan(input string tag, input logic [W-1:0] exp_d,
                       input bit exp_c, input bit per);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (valid) begin
            got = 1'b1;
            break;
         end
      end
      chk({tag, "_vld"}, got, 1);
      if (got) begin
         chk({tag, "_data"}, data, exp_d);
         chk({tag, "_chg"}, changed, exp_c);
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_ldlen"}, n_ld, CD);
         chk({tag, "_rises"}, n_rise, W);
         if (per) chk({tag, "_period"}, n_cyc, PER);
      end
      clr();
      tick();
      chk({tag, "_vld_off"}, valid, 0);
      chk({tag, "_chg_off"}, changed, 0);
      chk({tag, "_hold"}, data, exp_d);
      chk({tag, "_idle"}, busy, 0);
   endtask

   // Reference: a snapshot is "changed" if it is the first since reset
   // or differs from the previous snapshot
   task automatic do_scan(input string tag, input logic [W-1:0] val,
                          input bit per);
      bit exp_c;
      preset    = val;
      exp_c     = ref_first || (val != ref_last);
      ref_first = 1'b0;
      ref_last  = val;
      scan(tag, val, exp_c, per);
   endtask

   task automatic wait_rises(input string tag, input int n, input bit lvl);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (n_rise == n && sh_clk == lvl) begin
            ok = 1'b1;
            break;
         end
      end
      chk(tag, ok, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      n_chk     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      en        = 1'b1;
      preset    = 8'hA5;
      ref_first = 1'b1;
      ref_last  = '0;
      p_clk     = 1'b0;
      clr();
      repeat (3) @(negedge clk);
      chk("rst_ld_n", sh_ld_n, 1);
      chk("rst_clk", sh_clk, 0);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_chg", changed, 0);
      chk("rst_busy", busy, 0);

      @(posedge clk);
      #1 rst_n = 1'b1;
      clr();
      c = 0;
      for (int k = 1; k <= 50; k++) begin
         tick();
         if (!sh_ld_n) begin
            c = k;
            break;
         end
      end
      chk("first_load", c, GAP + 1);

      do_scan("a5", 8'hA5, 1'b0);
      do_scan("a5_again", 8'hA5, 1'b1);
      do_scan("5a", 8'h5A, 1'b1);
      do_scan("msb", 8'h80, 1'b1);
      chk("msb_bit7", data[7], 1);
      do_scan("lsb", 8'h01, 1'b1);
      chk("lsb_bit0", data[0], 1);
      chk("lsb_rest", data[7:1], 0);

      v      = 8'($urandom);
      preset = v;
      wait_rises("en_drop_wait", 3, 1'b0);
      en = 1'b0;
      do_scan("en_drop", v, 1'b1);
      repeat (60) tick();
      chk("park_ld", n_ld, 0);
      chk("park_rise", n_rise, 0);
      chk("park_busy", busy, 0);
      v      = ~ref_last;
      preset = v;
      @(posedge clk);
      #1 en = 1'b1;
      tick();
      chk("en_rise_idle", sh_ld_n, 1);
      tick();
      chk("en_rise_load", sh_ld_n, 0);
      do_scan("en_back", v, 1'b0);

      preset = ref_last;
      wait_rises("rst_wait", 6, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_clk", sh_clk, 0);
      chk("mid_rst_ld_n", sh_ld_n, 1);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", valid, 0);
      ref_first = 1'b1;
      ref_last  = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      clr();
      p_clk = 1'b0;
      do_scan("post_rst", preset, 1'b0);

      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            v = ref_last;
         end else begin
            v = 8'($urandom);
         end
         do_scan("rnd", v, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
